// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register, MSB first.
// Loads a WIDTH-bit word on LD & RDY and streams it out one bit per clock.
module piso_shift_reg #(
    parameter int WIDTH = 2
) (
    input  logic             C,
    input  logic             nR,
    input  logic [WIDTH-1:0] P,
    input  logic             LD,
    output logic             RDY,
    output logic             S,
    output logic             nS,
    output logic             VLD,
    output logic             LAST
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             at_last;

    assign at_last = (state == SHIFT) && (cnt == CNT_MAX);

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (LD) begin
                        shreg <= P;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!at_last) begin
                        shreg <= shreg << 1;
                        cnt   <= cnt + 1'b1;
                    end else if (LD) begin
                        // next word follows with no idle gap
                        shreg <= P;
                        cnt   <= '0;
                    end else begin
                        shreg <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // outputs decode registers only, never LD or P
    assign S    = (state == SHIFT) & shreg[WIDTH-1];
    assign nS   = ~S;
    assign VLD  = (state == SHIFT);
    assign LAST = at_last;
    assign RDY  = (state == IDLE) | at_last;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: WIDTH 2, 8 and 1 instances side by side.
// Directed scenarios plus randomized traffic against a word/position model.
module tb_piso_shift_reg;

    logic C = 1'b0;
    always #5 C = ~C;

    logic [2:0]  nr;
    logic [2:0]  ld;
    logic [31:0] p [3];
    logic [2:0]  s, ns, vld, last, rdy;

    int checks   = 0;
    int failures = 0;

    piso_shift_reg #(.WIDTH(2)) u_w2 (
        .C(C), .nR(nr[0]), .P(p[0][1:0]), .LD(ld[0]),
        .RDY(rdy[0]), .S(s[0]), .nS(ns[0]), .VLD(vld[0]), .LAST(last[0])
    );
    piso_shift_reg #(.WIDTH(8)) u_w8 (
        .C(C), .nR(nr[1]), .P(p[1][7:0]), .LD(ld[1]),
        .RDY(rdy[1]), .S(s[1]), .nS(ns[1]), .VLD(vld[1]), .LAST(last[1])
    );
    piso_shift_reg #(.WIDTH(1)) u_w1 (
        .C(C), .nR(nr[2]), .P(p[2][0:0]), .LD(ld[2]),
        .RDY(rdy[2]), .S(s[2]), .nS(ns[2]), .VLD(vld[2]), .LAST(last[2])
    );

    // model: which word is in flight and which bit index of it is on S
    int m_busy [3];
    int m_word [3];
    int m_pos  [3];
    int rk = -1;
    int acc_q [$];

    function automatic int wd(int k);
        return (k == 0) ? 2 : (k == 1) ? 8 : 1;
    endfunction

    task automatic model_edge(int k);
        int w = wd(k);
        if (!nr[k]) begin
            m_busy[k] = 0;
            m_pos[k]  = 0;
        end else if (ld[k] && (m_busy[k] == 0 || m_pos[k] == w - 1)) begin
            m_busy[k] = 1;
            m_word[k] = int'(p[k]) & ((1 << w) - 1);
            m_pos[k]  = 0;
            if (k == rk) acc_q.push_back(m_word[k]);
        end else if (m_busy[k] != 0 && m_pos[k] < w - 1) begin
            m_pos[k]++;
        end else begin
            m_busy[k] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge C);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
    endtask

    task automatic test_reset();
        nr = 3'b111;
        ld = 3'b000;
        for (int k = 0; k < 3; k++) begin
            p[k] = 0;
            m_busy[k] = 0;
            m_pos[k] = 0;
            m_word[k] = 0;
        end
        #1 nr = 3'b000;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({s[k], ns[k], vld[k], last[k], rdy[k]} !== 5'b01001) begin
                failures++;
                $display("FAIL reset_async k=%0d got S/nS/VLD/LAST/RDY=%b want 01001",
                         k, {s[k], ns[k], vld[k], last[k], rdy[k]});
            end
        end
        cycle();
        nr = 3'b111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({s[k], ns[k], vld[k], last[k], rdy[k]} !== 5'b01001) begin
                    failures++;
                    $display("FAIL reset_idle k=%0d cyc=%0d got %b want 01001",
                             k, i, {s[k], ns[k], vld[k], last[k], rdy[k]});
                end
            end
        end
    endtask

    task automatic test_single_w2();
        logic [1:0] rx = 2'b00;
        logic [1:0] es = 2'b10;
        logic [1:0] el = 2'b01;
        p[0] = 32'h2;
        ld[0] = 1'b1;
        cycle();
        ld[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({s[0], ns[0], vld[0], last[0], rdy[0]} !==
                {es[1-i], ~es[1-i], 1'b1, el[1-i], el[1-i]}) begin
                failures++;
                $display("FAIL single_w2 bit=%0d got S/nS/VLD/LAST/RDY=%b want %b",
                         i, {s[0], ns[0], vld[0], last[0], rdy[0]},
                         {es[1-i], ~es[1-i], 1'b1, el[1-i], el[1-i]});
            end
            rx = {rx[0], s[0]};
            cycle();
        end
        checks++;
        if (rx !== 2'b10) begin
            failures++;
            $display("FAIL single_w2_rx got Q2Q1=%b want 10", rx);
        end
        checks++;
        if ({s[0], vld[0], rdy[0]} !== 3'b001) begin
            failures++;
            $display("FAIL single_w2_idle got S/VLD/RDY=%b want 001",
                     {s[0], vld[0], rdy[0]});
        end
    endtask

    task automatic test_back_to_back_w2();
        logic [3:0] es = 4'b0111;
        logic [3:0] el = 4'b0101;
        p[0] = 32'h1;
        ld[0] = 1'b1;
        cycle();
        p[0] = 32'h3;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) ld[0] = 1'b0;
            checks++;
            if ({s[0], vld[0], last[0]} !== {es[3-i], 1'b1, el[3-i]}) begin
                failures++;
                $display("FAIL b2b_w2 cyc=%0d got S/VLD/LAST=%b want %b",
                         i, {s[0], vld[0], last[0]}, {es[3-i], 1'b1, el[3-i]});
            end
            cycle();
        end
        checks++;
        if (vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_w2_end got VLD=%b want 0", vld[0]);
        end
    endtask

    task automatic test_ignored_load_w8();
        logic [7:0] w = 8'hA5;
        p[1] = 32'hA5;
        ld[1] = 1'b1;
        cycle();
        ld[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                ld[1] = 1'b1;
                p[1] = 32'hFF;
            end
            if (i == 3) ld[1] = 1'b0;
            checks++;
            if ({s[1], vld[1], rdy[1]} !== {w[7-i], 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL ignored_w8 bit=%0d got S/VLD/RDY=%b want %b",
                         i, {s[1], vld[1], rdy[1]}, {w[7-i], 1'b1, (i == 7)});
            end
            cycle();
        end
        checks++;
        if (vld[1] !== 1'b0) begin
            failures++;
            $display("FAIL ignored_w8_end got VLD=%b want 0", vld[1]);
        end
    endtask

    task automatic test_midword_reset_w8();
        logic [7:0] w = 8'h3C;
        p[1] = 32'hC3;
        ld[1] = 1'b1;
        cycle();
        ld[1] = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        #2 nr[1] = 1'b0;
        #1;
        checks++;
        if ({s[1], ns[1], vld[1], last[1], rdy[1]} !== 5'b01001) begin
            failures++;
            $display("FAIL midreset_w8 got S/nS/VLD/LAST/RDY=%b want 01001",
                     {s[1], ns[1], vld[1], last[1], rdy[1]});
        end
        cycle();
        nr[1] = 1'b1;
        cycle();
        checks++;
        if (vld[1] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_w8_noresume got VLD=%b want 0", vld[1]);
        end
        p[1] = 32'h3C;
        ld[1] = 1'b1;
        cycle();
        ld[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({s[1], vld[1], last[1]} !== {w[7-i], 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL reload_w8 bit=%0d got S/VLD/LAST=%b want %b",
                         i, {s[1], vld[1], last[1]}, {w[7-i], 1'b1, (i == 7)});
            end
            cycle();
        end
    endtask

    task automatic test_w1();
        logic [2:0] seq = 3'b101;
        ld[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p[2] = {31'd0, seq[2-i]};
            cycle();
            checks++;
            if ({s[2], vld[2], last[2], rdy[2]} !== {seq[2-i], 3'b111}) begin
                failures++;
                $display("FAIL w1 cyc=%0d got S/VLD/LAST/RDY=%b want %b",
                         i, {s[2], vld[2], last[2], rdy[2]}, {seq[2-i], 3'b111});
            end
        end
        ld[2] = 1'b0;
        cycle();
        checks++;
        if ({vld[2], rdy[2]} !== 2'b01) begin
            failures++;
            $display("FAIL w1_end got VLD/RDY=%b want 01", {vld[2], rdy[2]});
        end
    endtask

    task automatic test_random(int k, int n);
        int w = wd(k);
        int rx = 0;
        int es, el, ev, er, got;
        acc_q.delete();
        rk = k;
        for (int i = 0; i < n; i++) begin
            ld[k] = ($urandom_range(0, 2) != 0);
            p[k]  = $urandom;
            cycle();
            ev = m_busy[k];
            es = (ev != 0) ? ((m_word[k] >> (w - 1 - m_pos[k])) & 1) : 0;
            el = (ev != 0 && m_pos[k] == w - 1) ? 1 : 0;
            er = (ev == 0 || el != 0) ? 1 : 0;
            checks++;
            if ({s[k], ns[k], vld[k], last[k], rdy[k]} !==
                {es[0], ~es[0], ev[0], el[0], er[0]}) begin
                failures++;
                $display("FAIL random k=%0d cyc=%0d got S/nS/VLD/LAST/RDY=%b want %b",
                         k, i, {s[k], ns[k], vld[k], last[k], rdy[k]},
                         {es[0], ~es[0], ev[0], el[0], er[0]});
            end
            if (vld[k]) rx = (rx << 1) | int'(s[k]);
            if (vld[k] && last[k]) begin
                got = (acc_q.size() > 0) ? acc_q.pop_front() : -1;
                checks++;
                if (rx !== got) begin
                    failures++;
                    $display("FAIL random_word k=%0d got %0h want %0h", k, rx, got);
                end
                rx = 0;
            end
        end
        ld[k] = 1'b0;
        rk = -1;
        for (int i = 0; i < w + 1; i++) cycle();
    endtask

    initial begin
        test_reset();
        test_single_w2();
        test_back_to_back_w2();
        test_ignored_load_w8();
        test_midword_reset_w8();
        test_w1();
        cycle();
        test_random(0, 300);
        test_random(1, 500);
        test_random(2, 200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
